// File: rtl/tinynpu_pkg.sv
// Shared NPU definitions: writeback FSM state encoding and the
// saturation bound helpers derived from the stored element width.
package tinynpu_pkg;

   typedef enum logic {
      WB_IDLE  = 1'b0,
      WB_WRITE = 1'b1
   } wb_state_t;

   // Largest value a signed element of width w can hold: 2^(w-1)-1.
   function automatic longint sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   // Smallest value a signed element of width w can hold: -2^(w-1).
   function automatic longint sat_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/result_writeback_if.sv
// Unified buffer write port as seen by a requester: request, address,
// packed row data and the grant returned by the buffer arbiter.
interface result_writeback_if #(
   parameter int N      = 4,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
);
   logic                  ub_wr_en;
   logic [ADDR_W-1:0]     ub_wr_addr;
   logic [N*DATA_W-1:0]   ub_wr_data;
   logic                  wr_gnt;

   modport master (
      output ub_wr_en,
      output ub_wr_addr,
      output ub_wr_data,
      input  wr_gnt
   );

   modport slave (
      input  ub_wr_en,
      input  ub_wr_addr,
      input  ub_wr_data,
      output wr_gnt
   );
endinterface

// File: rtl/result_writeback_requant_lane.sv
// One requantization lane: optional ReLU, arithmetic right shift, then
// saturation to the signed DATA_W range. Purely combinational.
// Optional feature macro: RESULT_WB_RELU_EN (clamp negatives to zero first).
module requant_lane
   import tinynpu_pkg::*;
#(
   parameter int ACC_W   = 32,
   parameter int DATA_W  = 16,
   parameter int SHIFT_W = 5
) (
   input  logic signed [ACC_W-1:0]   acc,
   input  logic        [SHIFT_W-1:0] shift,
   output logic        [DATA_W-1:0]  q
);

   localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'(sat_max(DATA_W));
   localparam logic signed [ACC_W-1:0] SAT_LO   = ACC_W'(sat_min(DATA_W));
   localparam logic        [DATA_W-1:0] SAT_HI_Q = DATA_W'(sat_max(DATA_W));
   localparam logic        [DATA_W-1:0] SAT_LO_Q = DATA_W'(sat_min(DATA_W));

   logic signed [ACC_W-1:0] pre;
   logic signed [ACC_W-1:0] shifted;

   // Rectify (optional), shift, then clamp into the stored range.
   always_comb begin
      // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
      pre = acc;
`ifdef RESULT_WB_RELU_EN
      if (acc[ACC_W-1]) begin
         pre = '0;
      end
`endif
      shifted = pre >>> shift;
      if (shifted > SAT_HI) begin
         q = SAT_HI_Q;
      end else if (shifted < SAT_LO) begin
         q = SAT_LO_Q;
      end else begin
         q = shifted[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/result_writeback.sv
// Drains an N x N accumulator tile into the unified buffer, one
// requantized row per write, arbitrating for the write port via wr_gnt.
// Optional feature macro: RESULT_WB_RELU_EN (non-negative stored range).
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module result_writeback
   import tinynpu_pkg::*;
#(
   parameter int N       = `ARRAY_SIZE,
   parameter int ACC_W   = `ACC_WIDTH,
   parameter int DATA_W  = `DATA_WIDTH,
   parameter int ADDR_W  = `ADDR_WIDTH,
   parameter int SHIFT_W = $clog2(ACC_W)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N*N*ACC_W-1:0]   results_flat,
   input  logic                   result_valid,
   input  logic [ADDR_W-1:0]      base_addr,
   input  logic [SHIFT_W-1:0]     shift,
   input  logic                   err_clr,
   result_writeback_if.master     ub,
   output logic                   busy,
   output logic                   done,
   output logic                   overrun
);

   localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

   wb_state_t              state;
   logic [ROW_W-1:0]       row;

   // Snapshot of the captured tile and its per-tile settings.
   logic [N*N*ACC_W-1:0]   tile_q;
   logic [ADDR_W-1:0]      base_q;
   logic [SHIFT_W-1:0]     shift_q;

   // Registered outputs.
   logic                   wr_en_q;
   logic [ADDR_W-1:0]      addr_q;
   logic [N*DATA_W-1:0]    data_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   overrun_q;

   // Lane inputs for the row that the output registers load next.
   logic [N*N*ACC_W-1:0]   sel_tile;
   logic [SHIFT_W-1:0]     sel_shift;
   logic [ROW_W-1:0]       sel_row;
   logic signed [ACC_W-1:0] lane_acc [N];
   logic [DATA_W-1:0]      lane_q   [N];
   logic [N*DATA_W-1:0]    lane_row;

   // Pick the row to requantize: row 0 straight from the inputs at
   // capture (the snapshot is not loaded yet), else the following row.
   always_comb begin
      sel_tile  = tile_q;
      sel_shift = shift_q;
      sel_row   = '0;
      if (state == WB_IDLE) begin
         sel_tile  = results_flat;
         sel_shift = shift;
      end else if (row != LAST_ROW) begin
         sel_row = row + ROW_W'(1);
      end
      for (int c = 0; c < N; c++) begin
         lane_acc[c] = sel_tile[(int'(sel_row) * N + c) * ACC_W +: ACC_W];
      end
   end

   for (genvar c = 0; c < N; c++) begin : g_lane
      requant_lane #(
         .ACC_W   (ACC_W),
         .DATA_W  (DATA_W),
         .SHIFT_W (SHIFT_W)
      ) u_lane (
         .acc   (lane_acc[c]),
         .shift (sel_shift),
         .q     (lane_q[c])
      );
   end

   // Pack lane results into one buffer word, lane c at [c*DATA_W +: DATA_W].
   always_comb begin
      lane_row = '0;
      for (int c = 0; c < N; c++) begin
         lane_row[c*DATA_W +: DATA_W] = lane_q[c];
      end
   end

   // Capture the tile and its settings when a strobe is accepted.
   always_ff @(posedge clk) begin
      // NOTE: the snapshot is pure data qualified by the FSM state, so it carries no reset.
      if (!rst && state == WB_IDLE && result_valid) begin
         tile_q  <= results_flat;
         base_q  <= base_addr;
         shift_q <= shift;
      end
   end

   // Writeback FSM: issue one row per grant, flag dropped tiles.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (rst) begin
         state     <= WB_IDLE;
         row       <= '0;
         wr_en_q   <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         done_q <= 1'b0;

         // A strobe while busy is dropped; setting beats clearing.
         if (result_valid && busy_q) begin
            overrun_q <= 1'b1;
         end else if (err_clr) begin
            overrun_q <= 1'b0;
         end

         case (state)
            WB_IDLE: begin
               if (result_valid) begin
                  state   <= WB_WRITE;
                  row     <= '0;
                  wr_en_q <= 1'b1;
                  busy_q  <= 1'b1;
                  addr_q  <= base_addr;
                  data_q  <= lane_row;
               end
            end
            WB_WRITE: begin
               if (ub.wr_gnt) begin
                  if (row == LAST_ROW) begin
                     state   <= WB_IDLE;
                     wr_en_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     row    <= sel_row;
                     addr_q <= base_q + ADDR_W'(sel_row);
                     data_q <= lane_row;
                  end
               end
            end
            default: state <= WB_IDLE;
         endcase
      end
   end

   assign ub.ub_wr_en   = wr_en_q;
   assign ub.ub_wr_addr = addr_q;
   assign ub.ub_wr_data = data_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_result_writeback.sv
// Directed testbench for result_writeback with N=4, ACC_W=32, DATA_W=16,
// ADDR_W=8. Expected values are hand-computed constants.
// Optional feature macro: RESULT_WB_RELU_EN selects the rectified expectations.
module tb_result_writeback;
   import tinynpu_pkg::*;

   localparam int N       = 4;
   localparam int ACC_W   = 32;
   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 8;
   localparam int SHIFT_W = 5;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N*N*ACC_W-1:0] results_flat;
   logic                 result_valid;
   logic [ADDR_W-1:0]    base_addr;
   logic [SHIFT_W-1:0]   shift;
   logic                 err_clr;
   logic                 busy;
   logic                 done;
   logic                 overrun;

   int n_checks = 0;
   int n_pass   = 0;

   logic [ADDR_W-1:0]   log_addr [$];
   logic [N*DATA_W-1:0] log_data [$];

   result_writeback_if #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) ub ();

   result_writeback #(
      .N       (N),
      .ACC_W   (ACC_W),
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .SHIFT_W (SHIFT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .results_flat (results_flat),
      .result_valid (result_valid),
      .base_addr    (base_addr),
      .shift        (shift),
      .err_clr      (err_clr),
      .ub           (ub.master),
      .busy         (busy),
      .done         (done),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   // Record every committed write (request and grant in the same cycle).
   always @(negedge clk) begin
      if (!rst && ub.ub_wr_en && ub.wr_gnt) begin
         log_addr.push_back(ub.ub_wr_addr);
         log_data.push_back(ub.ub_wr_data);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_seq();
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            results_flat[(r*N+c)*ACC_W +: ACC_W] = ACC_W'(4*r + c);
         end
      end
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
   endtask

   // Present a tile for one cycle; returns in cycle T+1.
   task automatic start_tile(input logic [ADDR_W-1:0] base, input logic [SHIFT_W-1:0] sh);
      result_valid = 1'b1;
      base_addr    = base;
      shift        = sh;
      tick();
      result_valid = 1'b0;
   endtask

   // Advance until done pulses, within a bounded number of cycles.
   task automatic wait_done(input string tag);
      for (int i = 0; i < 20 && !done; i++) begin
         tick();
      end
      check(tag, 64'(done), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      result_valid = 1'b0;
      results_flat = '0;
      base_addr    = '0;
      shift        = '0;
      err_clr      = 1'b0;
      ub.wr_gnt    = 1'b1;
      tick();
      tick();

      // Reset state.
      check("rst_en",      64'(ub.ub_wr_en),   64'd0);
      check("rst_addr",    64'(ub.ub_wr_addr), 64'd0);
      check("rst_data",    64'(ub.ub_wr_data), 64'd0);
      check("rst_busy",    64'(busy),          64'd0);
      check("rst_done",    64'(done),          64'd0);
      check("rst_overrun", 64'(overrun),       64'd0);
      rst = 1'b0;
      tick();

      // 1: sequential tile, full grant.
      clear_log();
      fill_seq();
      start_tile(8'h10, 5'd0);
      check("t1_en",    64'(ub.ub_wr_en),   64'd1);
      check("t1_busy",  64'(busy),          64'd1);
      check("t1_addr0", 64'(ub.ub_wr_addr), 64'h10);
      check("t1_row0",  ub.ub_wr_data,      64'h0003_0002_0001_0000);
      tick();
      check("t1_addr1", 64'(ub.ub_wr_addr), 64'h11);
      check("t1_row1",  ub.ub_wr_data,      64'h0007_0006_0005_0004);
      tick();
      tick();
      check("t1_busy_last", 64'(busy), 64'd1);
      check("t1_done_early", 64'(done), 64'd0);
      tick();
      check("t1_done",    64'(done),        64'd1);
      check("t1_busy_end", 64'(busy),       64'd0);
      check("t1_en_end",  64'(ub.ub_wr_en), 64'd0);
      tick();
      check("t1_done_pulse", 64'(done), 64'd0);
      check("t1_nwrites", 64'(log_addr.size()), 64'd4);
      if (log_addr.size() == 4) check("t1_addr3", 64'(log_addr[3]), 64'h13);

      // 2: saturation and shift.
      results_flat = '0;
      results_flat[0*ACC_W +: ACC_W] = 32'h0001_0000;
      results_flat[1*ACC_W +: ACC_W] = -32'sd70000;
      results_flat[2*ACC_W +: ACC_W] = 32'h0000_0100;
      results_flat[3*ACC_W +: ACC_W] = -32'sd1;
      results_flat[4*ACC_W +: ACC_W] = -32'sd5;
      start_tile(8'h30, 5'd0);
`ifdef RESULT_WB_RELU_EN
      check("t2_row0_sh0", ub.ub_wr_data, 64'h0000_0100_0000_7FFF);
      tick();
      check("t2_row1_sh0", ub.ub_wr_data, 64'h0000_0000_0000_0000);
`else
      check("t2_row0_sh0", ub.ub_wr_data, 64'hFFFF_0100_8000_7FFF);
      tick();
      check("t2_row1_sh0", ub.ub_wr_data, 64'h0000_0000_0000_FFFB);
`endif
      wait_done("t2_done_sh0");
      start_tile(8'h30, 5'd4);
`ifdef RESULT_WB_RELU_EN
      check("t2_row0_sh4", ub.ub_wr_data, 64'h0000_0010_0000_1000);
      tick();
      check("t2_row1_sh4", ub.ub_wr_data, 64'h0000_0000_0000_0000);
`else
      check("t2_row0_sh4", ub.ub_wr_data, 64'hFFFF_0010_EEE9_1000);
      tick();
      check("t2_row1_sh4", ub.ub_wr_data, 64'h0000_0000_0000_FFFF);
`endif
      wait_done("t2_done_sh4");
      tick();

      // 3: grant withheld for 3 cycles while row 2 is presented.
      clear_log();
      fill_seq();
      start_tile(8'h20, 5'd0);
      tick();
      tick();
      ub.wr_gnt = 1'b0;
      check("t3_addr_r2", 64'(ub.ub_wr_addr), 64'h22);
      check("t3_data_r2", ub.ub_wr_data,      64'h000B_000A_0009_0008);
      tick();
      check("t3_en_hold",   64'(ub.ub_wr_en),   64'd1);
      check("t3_addr_hold", 64'(ub.ub_wr_addr), 64'h22);
      tick();
      check("t3_data_hold", ub.ub_wr_data, 64'h000B_000A_0009_0008);
      tick();
      ub.wr_gnt = 1'b1;
      check("t3_en_t6", 64'(ub.ub_wr_en), 64'd1);
      tick();
      check("t3_done_t7", 64'(done), 64'd0);
      tick();
      check("t3_done_t8", 64'(done), 64'd1);
      check("t3_nwrites", 64'(log_addr.size()), 64'd4);
      tick();

      // 4: overrun while busy; the first tile is written untouched.
      clear_log();
      fill_seq();
      start_tile(8'h40, 5'd0);
      tick();
      for (int i = 0; i < N*N; i++) results_flat[i*ACC_W +: ACC_W] = 32'h55;
      result_valid = 1'b1;
      base_addr    = 8'h80;
      tick();
      result_valid = 1'b0;
      check("t4_overrun", 64'(overrun), 64'd1);
      wait_done("t4_done");
      check("t4_nwrites", 64'(log_addr.size()), 64'd4);
      if (log_addr.size() == 4) begin
         check("t4_addr0", 64'(log_addr[0]), 64'h40);
         check("t4_data0", log_data[0], 64'h0003_0002_0001_0000);
         check("t4_data3", log_data[3], 64'h000F_000E_000D_000C);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("t4_clr", 64'(overrun), 64'd0);

      // 4b: strobe in the final commit cycle, with err_clr: set wins;
      // then a strobe in the done cycle is accepted.
      fill_seq();
      start_tile(8'h50, 5'd0);
      tick();
      tick();
      tick();
      result_valid = 1'b1;
      err_clr      = 1'b1;
      tick();
      result_valid = 1'b0;
      err_clr      = 1'b0;
      check("t4_last_overrun", 64'(overrun), 64'd1);
      check("t4_last_done",    64'(done),    64'd1);
      result_valid = 1'b1;
      base_addr    = 8'h60;
      err_clr      = 1'b1;
      tick();
      result_valid = 1'b0;
      err_clr      = 1'b0;
      check("t4_accept_busy", 64'(busy),          64'd1);
      check("t4_accept_addr", 64'(ub.ub_wr_addr), 64'h60);
      check("t4_clr2",        64'(overrun),       64'd0);
      wait_done("t4_accept_done");
      tick();

      // 5: address wrap.
      clear_log();
      start_tile(8'hFE, 5'd0);
      wait_done("t5_done");
      check("t5_nwrites", 64'(log_addr.size()), 64'd4);
      if (log_addr.size() == 4) begin
         check("t5_a0", 64'(log_addr[0]), 64'hFE);
         check("t5_a1", 64'(log_addr[1]), 64'hFF);
         check("t5_a2", 64'(log_addr[2]), 64'h00);
         check("t5_a3", 64'(log_addr[3]), 64'h01);
      end
      tick();

      // 6: reset mid-tile, then a normal tile.
      clear_log();
      fill_seq();
      start_tile(8'h70, 5'd0);
      tick();
      tick();
      rst       = 1'b1;
      ub.wr_gnt = 1'b0;
      tick();
      rst       = 1'b0;
      ub.wr_gnt = 1'b1;
      check("t6_en",   64'(ub.ub_wr_en), 64'd0);
      check("t6_busy", 64'(busy),        64'd0);
      check("t6_done", 64'(done),        64'd0);
      tick();
      tick();
      tick();
      check("t6_nwrites", 64'(log_addr.size()), 64'd2);
      clear_log();
      start_tile(8'h90, 5'd0);
      check("t6_row0", ub.ub_wr_data, 64'h0003_0002_0001_0000);
      wait_done("t6_done_new");
      check("t6_nwrites_new", 64'(log_addr.size()), 64'd4);
      if (log_addr.size() == 4) begin
         check("t6_addr3", 64'(log_addr[3]), 64'h93);
         check("t6_data3", log_data[3], 64'h000F_000E_000D_000C);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/result_writeback.md
# result_writeback

Drain-side counterpart of the NPU load path. Captures the N×N accumulator tile from the systolic array on `result_valid`, requantizes each accumulator to `DATA_WIDTH` (arithmetic shift + saturation), packs one tile row per buffer word, and writes the rows back into the unified buffer through its write port. It sits between the systolic array outputs and the unified buffer write interface, alongside the host loader, and arbitrates for that port with a grant handshake.

## Interface
Parameters:
- `N`, default `` `ARRAY_SIZE ``: tile dimension.
- `ACC_W`, default `` `ACC_WIDTH ``: accumulator width.
- `DATA_W`, default `` `DATA_WIDTH ``: stored element width.
- `ADDR_W`, default `` `ADDR_WIDTH ``: buffer address width.
- `SHIFT_W`, default `$clog2(ACC_W)`: shift field width.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `results_flat`  in  N*N*ACC_W  tile; element (r,c) is signed at bits [(r*N+c)*ACC_W +: ACC_W].
- `result_valid`  in  1  single-cycle tile-valid strobe.
- `base_addr`  in  ADDR_W  destination of row 0; sampled at capture.
- `shift`  in  SHIFT_W  right-shift amount; sampled at capture.
- `wr_gnt`  in  1  buffer write port granted this cycle.
- `err_clr`  in  1  clears `overrun`.
- `ub_wr_en`  out  1  write request.
- `ub_wr_addr`  out  ADDR_W  write address.
- `ub_wr_data`  out  N*DATA_W  packed row; lane c at [c*DATA_W +: DATA_W].
- `busy`  out  1  tile held, writes pending.
- `done`  out  1  one-cycle pulse after the last row commits.
- `overrun`  out  1  sticky; tile dropped.

## Operation
- FSM with two states, IDLE and WRITE. A row counter `row` runs 0..N-1.
- IDLE with `result_valid`=1:
  - Snapshot the full tile, `base_addr` and `shift`.
  - Go to WRITE with `row`=0.
  - Load the output registers with row 0.
- WRITE:
  - `ub_wr_en`=1, `ub_wr_addr`=base+row (mod 2^ADDR_W), `ub_wr_data` = requantized row `row`.
  - A row commits on any cycle with `ub_wr_en`&&`wr_gnt`.
  - On commit of row<N-1: `row`++ and the output registers load the next row.
  - On commit of row N-1: go to IDLE, `ub_wr_en`→0, pulse `done`.
- Requantize per element:
  - v = acc >>> shift (arithmetic).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- `result_valid` while `busy`=1:
  - The strobe is ignored and the snapshot is unchanged.
  - `overrun`←1.
- `err_clr` clears `overrun`. If `err_clr` and a new overrun occur in the same cycle, set wins.
- `rst`:
  - Abandons any operation.
  - All outputs 0, state IDLE, `row`=0.
  - Rows already committed stay in the buffer; no further writes are issued.

## Timing
- Reset value of every output: 0.
- Tile captured at edge T (`result_valid` high in cycle T).
- First request presented in cycle T+1.
- With `wr_gnt` constantly 1: rows commit in cycles T+1..T+N, and `done`=1 with `busy`=0 in cycle T+N+1.
- `busy`=1 from T+1 through the final commit cycle.
- A new `result_valid` is accepted in the `done` cycle.
- `result_valid` in the final commit cycle is an overrun.
- `ub_wr_addr`/`ub_wr_data` are registered and stay stable while `ub_wr_en`=1 and `wr_gnt`=0. Each cycle of `wr_gnt`=0 adds one cycle of latency.
- No combinational path from any input to any output.

## Configuration
- `RESULT_WB_RELU_EN` defined:
  - Negative accumulators are forced to 0 before shift and saturation.
  - Stored range is [0, 2^(DATA_W-1)-1].
- `RESULT_WB_RELU_EN` undefined: signed requantization as described under Operation.

## Structure
- Shared package `tinynpu_pkg` holds:
  - `wb_state_t` enum {WB_IDLE, WB_WRITE}.
  - The saturation bound constants derived from `DATA_W`.
- Sub-module `requant_lane`: one element through optional ReLU, shift and saturate; combinational. Instantiated N times on the selected snapshot row.
- The snapshot register and FSM live in `result_writeback`.

## Test plan
Values assume N=4, ACC_W=32, DATA_W=16.
1. Tile (r,c)=4r+c, shift=0, base=0x10, `wr_gnt`=1 → writes to 0x10..0x13 in T+1..T+4; row 1 data = 0x0007_0006_0005_0004; `done` pulses at T+5.
2. Saturation and shift, shift=0 and 4:
   - 0x0001_0000 at shift 0 → 0x7FFF.
   - -70000 at shift 0 → 0x8000.
   - 0x100 at shift 4 → 0x0010.
   - -1 at shift 4 → 0xFFFF.
   - With `RESULT_WB_RELU_EN`: -5 → 0x0000.
3. `wr_gnt`=0 for 3 cycles while row 2 is presented → `ub_wr_en` held 1, addr/data unchanged; `done` at T+8.
4. Second `result_valid` at T+2 → `overrun`=1; all 4 writes carry the first tile; `err_clr` → `overrun`=0 next cycle.
5. base=2^ADDR_W-2 → addresses 2^ADDR_W-2, 2^ADDR_W-1, 0, 1.
6. `rst` asserted in the cycle after row 1 commits → next cycle `ub_wr_en`=0, `busy`=0, `done`=0; no further writes; the next tile is processed normally.
